// File: rtl/exec_pkg.sv
// Shared opcode map, flag bit positions and decode helpers for the execute stage.
package exec_pkg;

  localparam int DATA_W = 16;
  localparam int NFLAGS = 5;

  // op_hi for I-type / shift group; R-type reuses the same codes in op_ext
  localparam logic [3:0] OP_R     = 4'h0;
  localparam logic [3:0] OP_AND   = 4'h1;
  localparam logic [3:0] OP_OR    = 4'h2;
  localparam logic [3:0] OP_XOR   = 4'h3;
  localparam logic [3:0] OP_ADD   = 4'h5;
  localparam logic [3:0] OP_SHIFT = 4'h8;
  localparam logic [3:0] OP_SUB   = 4'h9;
  localparam logic [3:0] OP_CMP   = 4'hB;
  localparam logic [3:0] OP_MOV   = 4'hD;
  localparam logic [3:0] OP_LUI   = 4'hF;
  localparam logic [3:0] OPX_LSH  = 4'h4;

  localparam int FLAG_C = 0;
  localparam int FLAG_L = 1;
  localparam int FLAG_F = 2;
  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 4;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_CMP, ALU_AND, ALU_OR, ALU_XOR,
    ALU_MOV, ALU_LSH, ALU_LSHI, ALU_ILL
  } alu_op_e;

  function automatic alu_op_e alu_decode(input logic [7:0] op, input logic imm_sel);
    logic [3:0] hi;
    logic [3:0] ext;
    logic [3:0] sel;
    hi  = op[7:4];
    ext = op[3:0];
    sel = imm_sel ? hi : ext;
    alu_decode = ALU_ILL;
    if (hi == OP_SHIFT) begin
      if (ext == OPX_LSH)       alu_decode = ALU_LSH;
      else if (ext[3:1] == 3'b000) alu_decode = ALU_LSHI;
    end else if (imm_sel || hi == OP_R) begin
      case (sel)
        OP_ADD:  alu_decode = ALU_ADD;
        OP_SUB:  alu_decode = ALU_SUB;
        OP_CMP:  alu_decode = ALU_CMP;
        OP_AND:  alu_decode = ALU_AND;
        OP_OR:   alu_decode = ALU_OR;
        OP_XOR:  alu_decode = ALU_XOR;
        OP_MOV:  alu_decode = ALU_MOV;
        OP_LUI:  alu_decode = imm_sel ? ALU_MOV : ALU_ILL;
        default: alu_decode = ALU_ILL;
      endcase
    end
  endfunction

  // Immediate operand shaping keyed on the I-type op_hi
  function automatic logic [DATA_W-1:0] imm_b(input logic [3:0] op_hi, input logic [DATA_W-1:0] imm16);
    case (op_hi)
      OP_ADD, OP_SUB, OP_CMP: imm_b = imm16;
      OP_LUI:                 imm_b = {imm16[7:0], 8'h00};
      default:                imm_b = {8'h00, imm16[7:0]};
    endcase
  endfunction

endpackage

// File: rtl/exec_alu.sv
// Combinational ALU: operands + opcode -> result, next flags, write-enable, illegal.
module exec_alu
  import exec_pkg::*;
(
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic [7:0]        i_op,
  input  logic              i_imm_sel,
  input  logic [NFLAGS-1:0] i_flags,
  output logic [DATA_W-1:0] o_res,
  output logic [NFLAGS-1:0] o_flags,
  output logic              o_wr_ok,
  output logic              o_illegal
);
  localparam int MSB = DATA_W - 1;

  alu_op_e         w_kind;
  logic [DATA_W:0] w_sum;
  logic [DATA_W:0] w_diff;
  logic [4:0]      w_rneg;

  assign w_kind = alu_decode(i_op, i_imm_sel);
  assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
  assign w_diff = {1'b0, i_a} - {1'b0, i_b};
  // magnitude of a negative LSH amount; bit 4 set only for -16
  assign w_rneg = 5'd0 - i_b[4:0];

  always_comb begin
    o_res     = '0;
    o_flags   = i_flags;
    o_wr_ok   = 1'b1;
    o_illegal = 1'b0;
    case (w_kind)
      ALU_ADD: begin
        o_res           = w_sum[MSB:0];
        o_flags[FLAG_C] = w_sum[DATA_W];
        o_flags[FLAG_F] = (i_a[MSB] == i_b[MSB]) && (w_sum[MSB] != i_a[MSB]);
        o_flags[FLAG_Z] = (w_sum[MSB:0] == '0);
        o_flags[FLAG_N] = w_sum[MSB];
      end
      ALU_SUB: begin
        o_res           = w_diff[MSB:0];
        o_flags[FLAG_C] = w_diff[DATA_W];
        o_flags[FLAG_F] = (i_a[MSB] != i_b[MSB]) && (w_diff[MSB] != i_a[MSB]);
        o_flags[FLAG_Z] = (w_diff[MSB:0] == '0);
        o_flags[FLAG_N] = w_diff[MSB];
      end
      ALU_CMP: begin
        o_res           = w_diff[MSB:0];
        o_wr_ok         = 1'b0;
        o_flags[FLAG_Z] = (i_a == i_b);
        o_flags[FLAG_N] = ($signed(i_a) < $signed(i_b));
        o_flags[FLAG_L] = (i_a < i_b);
      end
      ALU_AND:  o_res = i_a & i_b;
      ALU_OR:   o_res = i_a | i_b;
      ALU_XOR:  o_res = i_a ^ i_b;
      ALU_MOV:  o_res = i_b;
      ALU_LSH: begin
        if (i_b[4]) o_res = w_rneg[4] ? '0 : (i_a >> w_rneg[3:0]);
        else        o_res = i_a << i_b[3:0];
      end
      ALU_LSHI: o_res = i_op[0] ? (i_a >> i_b[3:0]) : (i_a << i_b[3:0]);
      default: begin
        o_res     = '0;
        o_wr_ok   = 1'b0;
        o_illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/exec_regfile_alu.sv
// Execute/writeback stage: 16x16 regfile, ALU, PSR flags, sticky illegal flag.
// Define REG0_ZERO_EN to hardwire r0 to zero (writes dropped, reads return 0).
module exec_regfile_alu
  import exec_pkg::*;
#(
  parameter int                NREGS   = 16,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              w_en,
  input  logic [3:0]        rsrc,
  input  logic [3:0]        rdest,
  input  logic [7:0]        opcode,
  input  logic              imm_sel,
  input  logic [DATA_W-1:0] imm16,
  output logic [DATA_W-1:0] result_q,
  output logic [NFLAGS-1:0] flags_q,
  output logic              illegal_q,
  input  logic [3:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);
  logic [NREGS-1:0][DATA_W-1:0] r_regs;
  logic [DATA_W-1:0]            r_result;
  logic [NFLAGS-1:0]            r_flags;
  logic                         r_illegal;

  logic [DATA_W-1:0] w_a, w_b, w_rs, w_res;
  logic [NFLAGS-1:0] w_flags;
  logic              w_wr_ok, w_ill, w_wr;

  function automatic logic [DATA_W-1:0] rd_reg(input logic [3:0] idx);
`ifdef REG0_ZERO_EN
    rd_reg = (idx == 4'd0) ? '0 : r_regs[idx];
`else
    rd_reg = r_regs[idx];
`endif
  endfunction

  assign w_a      = rd_reg(rdest);
  assign w_rs     = rd_reg(rsrc);
  assign dbg_data = rd_reg(dbg_addr);

  // Shift group ignores imm_sel: LSH takes reg[rsrc], LSHI takes imm16[3:0]
  always_comb begin
    w_b = w_rs;
    if (opcode[7:4] == OP_SHIFT) begin
      if (opcode[3:0] != OPX_LSH) w_b = {{(DATA_W-4){1'b0}}, imm16[3:0]};
    end else if (imm_sel) begin
      w_b = imm_b(opcode[7:4], imm16);
    end
  end

  exec_alu u_alu (
    .i_a      (w_a),
    .i_b      (w_b),
    .i_op     (opcode),
    .i_imm_sel(imm_sel),
    .i_flags  (r_flags),
    .o_res    (w_res),
    .o_flags  (w_flags),
    .o_wr_ok  (w_wr_ok),
    .o_illegal(w_ill)
  );

`ifdef REG0_ZERO_EN
  assign w_wr = w_wr_ok && (rdest != 4'd0);
`else
  assign w_wr = w_wr_ok;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_regs    <= {NREGS{RST_VAL}};
      r_result  <= RST_VAL;
      r_flags   <= '0;
      r_illegal <= 1'b0;
    end else if (w_en) begin
      if (w_wr) r_regs[rdest] <= w_res;
      r_result <= w_res;
      r_flags  <= w_flags;
      if (w_ill) r_illegal <= 1'b1;
    end
  end

  assign result_q  = r_result;
  assign flags_q   = r_flags;
  assign illegal_q = r_illegal;

endmodule
